// File: rtl/ibex_pmp_csr_if.sv
// PMP CSR payload types and the CSR-unit <-> PMP CSR bank port interface.
package ibex_pmp_csr_pkg;

  localparam int unsigned PmpModeW = 2;

  typedef struct packed {
    logic                lock;
    logic [PmpModeW-1:0] mode;
    logic                exec;
    logic                write;
    logic                read;
  } pmp_cfg_t;

  typedef struct packed {
    logic rlb;
    logic mmwp;
    logic mml;
  } pmp_mseccfg_t;

  localparam logic [PmpModeW-1:0] PMP_MODE_OFF   = 2'd0;
  localparam logic [PmpModeW-1:0] PMP_MODE_TOR   = 2'd1;
  localparam logic [PmpModeW-1:0] PMP_MODE_NA4   = 2'd2;
  localparam logic [PmpModeW-1:0] PMP_MODE_NAPOT = 2'd3;

endpackage

interface ibex_pmp_csr_if;

  localparam int unsigned CsrAddrW = 12;
  localparam int unsigned CsrDataW = 32;

  logic                csr_we;
  logic [CsrAddrW-1:0] csr_addr;
  logic [CsrDataW-1:0] csr_wdata;
  logic [CsrDataW-1:0] csr_rdata;
  logic                csr_hit;
  logic                csr_wr_ignored;

  modport master (
    output csr_we, csr_addr, csr_wdata,
    input  csr_rdata, csr_hit, csr_wr_ignored
  );

  modport slave (
    input  csr_we, csr_addr, csr_wdata,
    output csr_rdata, csr_hit, csr_wr_ignored
  );

endinterface

// File: rtl/ibex_pmp_csr.sv
// PMP CSR bank (pmpcfg/pmpaddr/mseccfg) feeding the PMP checker from flops.
// Optional parity protection enabled by defining IBEX_PMP_CSR_PARITY_EN.
module ibex_pmp_csr
  import ibex_pmp_csr_pkg::*;
#(
  parameter int unsigned PMPGranularity = 0,
  parameter int unsigned PMPNumRegions  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  ibex_pmp_csr_if.slave      csr_bus,
  output pmp_cfg_t           csr_pmp_cfg_o     [PMPNumRegions],
  output logic [33:0]        csr_pmp_addr_o    [PMPNumRegions],
  output pmp_mseccfg_t       csr_pmp_mseccfg_o,
  output logic               pmp_csr_err_o
);

  localparam int unsigned AddrW = 32;

  localparam logic [11:0] CsrPmpCfgBase  = 12'h3A0;
  localparam logic [11:0] CsrPmpAddrBase = 12'h3B0;
  localparam logic [11:0] CsrMseccfg     = 12'h747;
  localparam logic [11:0] CsrMseccfgh    = 12'h757;

  function automatic logic [AddrW-1:0] low_mask(input int n);
    logic [AddrW-1:0] m;
    m = '0;
    for (int b = 0; b < int'(AddrW); b++) begin
      if (b < n) m[b] = 1'b1;
    end
    return m;
  endfunction

  function automatic pmp_cfg_t to_cfg(input logic [7:0] b);
    pmp_cfg_t c;
    c.lock  = b[7];
    c.mode  = b[4:3];
    c.exec  = b[2];
    c.write = b[1];
    c.read  = b[0];
    return c;
  endfunction

  // NAPOT reads force the low G-1 bits to 1; OFF/TOR reads force the low G bits to 0.
  localparam logic [AddrW-1:0] NapotOnes = low_mask(int'(PMPGranularity) - 1);
  localparam logic [AddrW-1:0] TorZeros  = low_mask(int'(PMPGranularity));

  pmp_cfg_t           cfg_q    [PMPNumRegions];
  pmp_cfg_t           cfg_new  [PMPNumRegions];
  logic [AddrW-1:0]   addr_q   [PMPNumRegions];
  pmp_mseccfg_t       msec_q, msec_new;
  logic [PMPNumRegions-1:0] cfg_wr, addr_wr, tor_lock_next;
  logic               msec_wr;
  logic               wr_ignored_q, wr_ignored_d;
  logic               any_lock;
  logic               is_cfg, is_addr, is_msec, is_msech;
  logic [31:0]        rdata_c;
  logic               unused_wdata;

  assign is_cfg   = csr_bus.csr_addr[11:2] == CsrPmpCfgBase[11:2];
  assign is_addr  = csr_bus.csr_addr[11:4] == CsrPmpAddrBase[11:4];
  assign is_msec  = csr_bus.csr_addr == CsrMseccfg;
  assign is_msech = csr_bus.csr_addr == CsrMseccfgh;

  assign unused_wdata = ^csr_bus.csr_wdata;

  // A locked TOR region also protects the pmpaddr entry just below it.
  always_comb begin
    tor_lock_next = '0;
    any_lock      = 1'b0;
    for (int unsigned i = 0; i + 1 < PMPNumRegions; i++) begin
      tor_lock_next[i] = cfg_q[i+1].lock && (cfg_q[i+1].mode == PMP_MODE_TOR);
    end
    for (int unsigned r = 0; r < PMPNumRegions; r++) begin
      any_lock = any_lock | cfg_q[r].lock;
    end
  end

  // Write legalisation; every lock check uses the current (pre-write) state.
  always_comb begin
    pmp_cfg_t wcfg;
    wcfg         = '0;
    cfg_wr       = '0;
    addr_wr      = '0;
    msec_wr      = 1'b0;
    msec_new     = msec_q;
    wr_ignored_d = 1'b0;
    for (int unsigned r = 0; r < PMPNumRegions; r++) begin
      cfg_new[r] = cfg_q[r];
    end

    for (int unsigned r = 0; r < PMPNumRegions; r++) begin
      if (csr_bus.csr_we && is_cfg && (csr_bus.csr_addr[1:0] == 2'(r / 4))) begin
        wcfg = to_cfg(csr_bus.csr_wdata[8*(r%4) +: 8]);
        if (cfg_q[r].lock && !msec_q.rlb) begin
          wr_ignored_d = 1'b1;
        end else if (!wcfg.read && wcfg.write && !msec_q.mml) begin
          wr_ignored_d = 1'b1;
        end else if (msec_q.mml && !msec_q.rlb && wcfg.lock &&
                     (wcfg.exec || (!wcfg.read && wcfg.write))) begin
          wr_ignored_d = 1'b1;
        end else begin
          cfg_wr[r]  = 1'b1;
          cfg_new[r] = wcfg;
          if ((PMPGranularity >= 1) && (wcfg.mode == PMP_MODE_NA4)) begin
            cfg_new[r].mode = cfg_q[r].mode;
            wr_ignored_d    = 1'b1;
          end
        end
      end
    end

    for (int unsigned i = 0; i < PMPNumRegions; i++) begin
      if (csr_bus.csr_we && is_addr && (csr_bus.csr_addr[3:0] == 4'(i))) begin
        if ((cfg_q[i].lock || tor_lock_next[i]) && !msec_q.rlb) begin
          wr_ignored_d = 1'b1;
        end else begin
          addr_wr[i] = 1'b1;
        end
      end
    end

    // MML/MMWP are set-only; RLB moves only while no lock can be bypassed by it.
    if (csr_bus.csr_we && is_msec) begin
      msec_wr       = 1'b1;
      msec_new.mml  = msec_q.mml  | csr_bus.csr_wdata[0];
      msec_new.mmwp = msec_q.mmwp | csr_bus.csr_wdata[1];
      if (msec_q.rlb || !any_lock) begin
        msec_new.rlb = csr_bus.csr_wdata[2];
      end else begin
        wr_ignored_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned r = 0; r < PMPNumRegions; r++) begin
        cfg_q[r]  <= '0;
        addr_q[r] <= '0;
      end
      msec_q       <= '0;
      wr_ignored_q <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < PMPNumRegions; r++) begin
        if (cfg_wr[r])  cfg_q[r]  <= cfg_new[r];
        if (addr_wr[r]) addr_q[r] <= csr_bus.csr_wdata;
      end
      if (msec_wr) msec_q <= msec_new;
      wr_ignored_q <= wr_ignored_d;
    end
  end

  // Read mux; unimplemented regions fall through as zero.
  always_comb begin
    rdata_c = '0;
    for (int unsigned r = 0; r < PMPNumRegions; r++) begin
      if (is_cfg && (csr_bus.csr_addr[1:0] == 2'(r / 4))) begin
        rdata_c[8*(r%4) +: 8] = {cfg_q[r].lock, 2'b00, cfg_q[r].mode,
                                 cfg_q[r].exec, cfg_q[r].write, cfg_q[r].read};
      end
      if (is_addr && (csr_bus.csr_addr[3:0] == 4'(r))) begin
        case (cfg_q[r].mode)
          PMP_MODE_NAPOT:             rdata_c = addr_q[r] | NapotOnes;
          PMP_MODE_OFF, PMP_MODE_TOR: rdata_c = addr_q[r] & ~TorZeros;
          default:                    rdata_c = addr_q[r];
        endcase
      end
    end
    if (is_msec) rdata_c = {29'd0, msec_q};
  end

  assign csr_bus.csr_rdata      = rdata_c;
  assign csr_bus.csr_hit        = is_cfg | is_addr | is_msec | is_msech;
  assign csr_bus.csr_wr_ignored = wr_ignored_q;
  assign csr_pmp_mseccfg_o      = msec_q;

  always_comb begin
    for (int unsigned r = 0; r < PMPNumRegions; r++) begin
      csr_pmp_cfg_o[r]  = cfg_q[r];
      csr_pmp_addr_o[r] = {addr_q[r], 2'b00};
    end
  end

`ifdef IBEX_PMP_CSR_PARITY_EN
  logic [PMPNumRegions-1:0] cfg_par_q, addr_par_q;
  logic                     msec_par_q, err_q, par_mismatch;

  always_comb begin
    par_mismatch = (^msec_q) ^ msec_par_q;
    for (int unsigned r = 0; r < PMPNumRegions; r++) begin
      par_mismatch = par_mismatch | ((^cfg_q[r]) ^ cfg_par_q[r]) |
                     ((^addr_q[r]) ^ addr_par_q[r]);
    end
  end

  // Parity follows accepted writes only; the error is sticky until reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_par_q  <= '0;
      addr_par_q <= '0;
      msec_par_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < PMPNumRegions; r++) begin
        if (cfg_wr[r])  cfg_par_q[r]  <= ^cfg_new[r];
        if (addr_wr[r]) addr_par_q[r] <= ^csr_bus.csr_wdata;
      end
      if (msec_wr) msec_par_q <= ^msec_new;
      err_q <= err_q | par_mismatch;
    end
  end

  assign pmp_csr_err_o = err_q;
`else
  assign pmp_csr_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_pmp_csr.sv
// Directed self-checking bench for ibex_pmp_csr: one 4 B-granule and one 16 B-granule instance.
module tb_ibex_pmp_csr;
  import ibex_pmp_csr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ibex_pmp_csr_if bus0 ();
  ibex_pmp_csr_if bus2 ();

  pmp_cfg_t     cfg0 [4];
  pmp_cfg_t     cfg2 [4];
  logic [33:0]  addr0 [4];
  logic [33:0]  addr2 [4];
  pmp_mseccfg_t msec0, msec2;
  logic         err0, err2;

  ibex_pmp_csr #(.PMPGranularity(0), .PMPNumRegions(4)) u_dut0 (
    .clk_i             (clk),
    .rst_i             (rst),
    .csr_bus           (bus0),
    .csr_pmp_cfg_o     (cfg0),
    .csr_pmp_addr_o    (addr0),
    .csr_pmp_mseccfg_o (msec0),
    .pmp_csr_err_o     (err0)
  );

  ibex_pmp_csr #(.PMPGranularity(2), .PMPNumRegions(4)) u_dut2 (
    .clk_i             (clk),
    .rst_i             (rst),
    .csr_bus           (bus2),
    .csr_pmp_cfg_o     (cfg2),
    .csr_pmp_addr_o    (addr2),
    .csr_pmp_mseccfg_o (msec2),
    .pmp_csr_err_o     (err2)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle write; returns on the falling edge after the capturing edge.
  task automatic wr(input bit sel, input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    if (sel) begin
      bus2.csr_we = 1'b1; bus2.csr_addr = a; bus2.csr_wdata = d;
    end else begin
      bus0.csr_we = 1'b1; bus0.csr_addr = a; bus0.csr_wdata = d;
    end
    @(negedge clk);
    bus0.csr_we = 1'b0;
    bus2.csr_we = 1'b0;
  endtask

  task automatic rd(input bit sel, input logic [11:0] a, input string tag, input logic [31:0] exp);
    if (sel) bus2.csr_addr = a;
    else     bus0.csr_addr = a;
    #1;
    chk(tag, 34'(sel ? bus2.csr_rdata : bus0.csr_rdata), 34'(exp));
  endtask

  initial begin
    bus0.csr_we = 1'b0; bus0.csr_addr = '0; bus0.csr_wdata = '0;
    bus2.csr_we = 1'b0; bus2.csr_addr = '0; bus2.csr_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    rd(0, 12'h3A0, "rst_cfg0", 32'h0);
    rd(0, 12'h3B0, "rst_addr0", 32'h0);
    rd(0, 12'h747, "rst_msec", 32'h0);
    chk("rst_mode", 34'(cfg0[0].mode), 34'(PMP_MODE_OFF));
    chk("hit_747", 34'(bus0.csr_hit), 34'd1);
    bus0.csr_addr = 12'h300; #1;
    chk("hit_300", 34'(bus0.csr_hit), 34'd0);
    chk("rst_ign", 34'(bus0.csr_wr_ignored), 34'd0);
    chk("rst_err", 34'(err0), 34'd0);

    // Lock on region1 blocks a later byte write but not its neighbour
    wr(0, 12'h3A0, 32'h0000_8F0F);
    chk("ign_a1", 34'(bus0.csr_wr_ignored), 34'd0);
    chk("cfg_r0", 34'(cfg0[0]), 34'h0F);
    chk("cfg_r1", 34'(cfg0[1]), 34'h2F);
    rd(0, 12'h3A0, "rd_cfg_a1", 32'h0000_8F0F);
    wr(0, 12'h3A0, 32'h0);
    chk("ign_a2", 34'(bus0.csr_wr_ignored), 34'd1);
    rd(0, 12'h3A0, "rd_cfg_a2", 32'h0000_8F00);
    @(posedge clk); #1;
    chk("ign_pulse_end", 34'(bus0.csr_wr_ignored), 34'd0);

    // TOR lock of region1 protects pmpaddr0; region1 lock protects pmpaddr1
    wr(0, 12'h3B0, 32'h1234);
    chk("ign_tor", 34'(bus0.csr_wr_ignored), 34'd1);
    rd(0, 12'h3B0, "rd_addr0_tor", 32'h0);
    chk("addr0_tor", addr0[0], 34'h0);
    wr(0, 12'h3B1, 32'h55);
    chk("ign_addr1", 34'(bus0.csr_wr_ignored), 34'd1);
    rd(0, 12'h3B1, "rd_addr1", 32'h0);
    wr(0, 12'h3B2, 32'hABCD);
    chk("ign_addr2", 34'(bus0.csr_wr_ignored), 34'd0);
    chk("addr2_out", addr0[2], 34'h2AF34);
    rd(0, 12'h3B2, "rd_addr2", 32'hABCD);
    wr(0, 12'h747, 32'h4);
    chk("ign_rlb_locked", 34'(bus0.csr_wr_ignored), 34'd1);
    rd(0, 12'h747, "rd_msec_a", 32'h0);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst2_cfg1", 34'(cfg0[1]), 34'h0);

    // RLB set before locking lets locked entries be rewritten
    wr(0, 12'h747, 32'h4);
    chk("ign_rlb_set", 34'(bus0.csr_wr_ignored), 34'd0);
    rd(0, 12'h747, "rd_rlb", 32'h4);
    chk("msec_rlb", 34'(msec0), 34'h4);
    wr(0, 12'h3A0, 32'h0000_8F00);
    rd(0, 12'h3A0, "rd_cfg_b1", 32'h0000_8F00);
    wr(0, 12'h3B0, 32'h1234);
    chk("ign_rlb_addr", 34'(bus0.csr_wr_ignored), 34'd0);
    chk("addr0_rlb", addr0[0], 34'h48D0);
    rd(0, 12'h3B0, "rd_addr0_rlb", 32'h1234);

    // R=0,W=1 reserved without MML, legal once MML is set
    wr(0, 12'h3A0, 32'h0000_8F02);
    chk("ign_rw01", 34'(bus0.csr_wr_ignored), 34'd1);
    rd(0, 12'h3A0, "rd_cfg_rw01", 32'h0000_8F00);
    wr(0, 12'h747, 32'h5);
    rd(0, 12'h747, "rd_msec_mml", 32'h5);
    wr(0, 12'h3A0, 32'h0000_8F02);
    chk("ign_rw01_mml", 34'(bus0.csr_wr_ignored), 34'd0);
    rd(0, 12'h3A0, "rd_cfg_mml", 32'h0000_8F02);
    chk("cfg_r0_mml", 34'(cfg0[0]), 34'h02);

    // Clearing RLB is allowed once; re-setting it with locks present is not
    wr(0, 12'h747, 32'h0);
    chk("ign_rlb_clr", 34'(bus0.csr_wr_ignored), 34'd0);
    rd(0, 12'h747, "rd_msec_clr", 32'h1);
    wr(0, 12'h747, 32'h4);
    chk("ign_rlb_reset", 34'(bus0.csr_wr_ignored), 34'd1);
    rd(0, 12'h747, "rd_msec_noset", 32'h1);

    // Unimplemented regions: silent discard
    wr(0, 12'h3A1, 32'hFFFF_FFFF);
    chk("ign_unimpl", 34'(bus0.csr_wr_ignored), 34'd0);
    rd(0, 12'h3A1, "rd_unimpl", 32'h0);

    // MML rules: locked executable rejected, locked R-only NAPOT accepted
    wr(0, 12'h3A0, 32'h998D_8F02);
    chk("ign_mml", 34'(bus0.csr_wr_ignored), 34'd1);
    rd(0, 12'h3A0, "rd_cfg_mmlrule", 32'h9900_8F02);
    chk("cfg_r3", 34'(cfg0[3]), 34'h39);
    wr(0, 12'h3B0, 32'h1);
    chk("ign_tor2", 34'(bus0.csr_wr_ignored), 34'd1);
    chk("addr0_tor2", addr0[0], 34'h48D0);
    rd(0, 12'h757, "rd_msech", 32'h0);
    chk("hit_757", 34'(bus0.csr_hit), 34'd1);

    // Sticky MML/MMWP
    wr(0, 12'h747, 32'h2);
    rd(0, 12'h747, "rd_sticky1", 32'h3);
    wr(0, 12'h747, 32'h0);
    rd(0, 12'h747, "rd_sticky2", 32'h3);

    // Asynchronous reset in the middle of a write cycle
    @(negedge clk);
    bus0.csr_we = 1'b1; bus0.csr_addr = 12'h3A0; bus0.csr_wdata = 32'h0000_0001;
    #2 rst = 1'b1;
    rd(0, 12'h747, "rd_async_rst", 32'h0);
    chk("async_cfg3", 34'(cfg0[3]), 34'h0);
    chk("async_msec", 34'(msec0), 34'h0);
    @(negedge clk);
    bus0.csr_we = 1'b0;
    rst = 1'b0;
    rd(0, 12'h3A0, "rd_lost_write", 32'h0);

    // Granularity 16 B read masking and NA4 rejection
    wr(1, 12'h3B0, 32'h0);
    wr(1, 12'h3A0, 32'h18);
    rd(1, 12'h3B0, "g2_napot0", 32'h1);
    wr(1, 12'h3A0, 32'h08);
    rd(1, 12'h3B0, "g2_tor0", 32'h0);
    wr(1, 12'h3B0, 32'h7);
    rd(1, 12'h3B0, "g2_tor7", 32'h4);
    chk("g2_addr_out", addr2[0], 34'h1C);
    wr(1, 12'h3A0, 32'h18);
    rd(1, 12'h3B0, "g2_napot7", 32'h7);
    wr(1, 12'h3A0, 32'h11);
    chk("g2_ign_na4", 34'(bus2.csr_wr_ignored), 34'd1);
    rd(1, 12'h3A0, "g2_na4_keep", 32'h19);
    wr(1, 12'h3A0, 32'h00);
    chk("g2_ign_off", 34'(bus2.csr_wr_ignored), 34'd0);
    rd(1, 12'h3B0, "g2_off7", 32'h4);

    chk("err0_end", 34'(err0), 34'd0);
    chk("err2_end", 34'(err2), 34'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
